// File: rtl/snes_pad_responder.sv
// SNES game pad emulator: captures the button word on host latch, then shifts it
// out LSB-first and active-low on each host pulse rising edge.
module snes_pad_responder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] buttons,
  input  logic        latch_in,
  input  logic        pulse_in,
  output logic        data_out,
  output logic        busy,
  output logic [4:0]  bit_count,
  output logic        frame_done
);

  typedef enum logic [1:0] {IDLE, LATCHED, SHIFT, DONE} state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] latchSync_q, pulseSync_q;
  logic                   latchHist_q, pulseHist_q;
  logic [15:0]            shadow_q, shadow_d;
  logic [4:0]             count_q, count_d;
  logic [15:0]            timer_q, timer_d;
  logic                   frameDone_q, frameDone_d;

  logic latchS, pulseS, latchRise, pulseRise;

  assign latchS    = latchSync_q[SYNC_STAGES-1];
  assign pulseS    = pulseSync_q[SYNC_STAGES-1];
  assign latchRise = latchS & ~latchHist_q;
  assign pulseRise = pulseS & ~pulseHist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      latchSync_q <= '0;
      pulseSync_q <= '0;
      latchHist_q <= 1'b0;
      pulseHist_q <= 1'b0;
      shadow_q    <= 16'hFFFF;
      count_q     <= 5'd0;
      timer_q     <= 16'd0;
      frameDone_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      latchSync_q <= {latchSync_q[SYNC_STAGES-2:0], latch_in};
      pulseSync_q <= {pulseSync_q[SYNC_STAGES-2:0], pulse_in};
      latchHist_q <= latchS;
      pulseHist_q <= pulseS;
      shadow_q    <= shadow_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      frameDone_q <= frameDone_d;
    end
  end

  // A latch rise from any state restarts the frame and outranks a same-cycle pulse.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    count_d     = count_q;
    timer_d     = timer_q;
    frameDone_d = 1'b0;
    if (latchRise) begin
      state_d  = LATCHED;
      shadow_d = ~buttons;
      count_d  = 5'd0;
      timer_d  = 16'd0;
    end else begin
      case (state_q)
        LATCHED: begin
          if (latchS) begin
            shadow_d = ~buttons;
            count_d  = 5'd0;
          end else begin
            state_d = SHIFT;
            timer_d = 16'd0;
          end
        end
        SHIFT: begin
          if (pulseRise) begin
            shadow_d = {1'b0, shadow_q[15:1]};
            count_d  = count_q + 5'd1;
            timer_d  = 16'd0;
            if (count_q == 5'd15) begin
              state_d     = DONE;
              frameDone_d = 1'b1;
            end
          end else if (timer_q == TIMEOUT_LAST) begin
            state_d = IDLE;
            timer_d = 16'd0;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    data_out = shadow_q[0];
    if (state_q == IDLE) data_out = 1'b1;
    else if (state_q == DONE) data_out = 1'b0;
  end

  assign busy       = (state_q == LATCHED) || (state_q == SHIFT);
  assign bit_count  = count_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Scoreboard bench for snes_pad_responder: expected serial bits are queued when a
// latch is driven and popped after each pulse once the DUT has had time to respond.
module tb_snes_pad_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] buttons;
  logic        latch_in;
  logic        pulse_in;
  logic        data_out;
  logic        busy;
  logic [4:0]  bit_count;
  logic        frame_done;

  int compared   = 0;
  int mismatched = 0;
  int fdCount    = 0;
  bit expQ[$];

  snes_pad_responder #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .buttons(buttons), .latch_in(latch_in),
    .pulse_in(pulse_in), .data_out(data_out), .busy(busy),
    .bit_count(bit_count), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_done === 1'b1) fdCount++;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Latch with a button value that may change late in the hold window; the final value wins.
  task automatic applyStimulus(input logic [15:0] first, input logic [15:0] last,
                               input int hold, input int changeBefore);
    logic [15:0] inv;
    expQ.delete();
    buttons  = first;
    latch_in = 1'b1;
    waitClk(hold - changeBefore);
    buttons = last;
    waitClk(changeBefore);
    latch_in = 1'b0;
    inv = ~last;
    for (int k = 0; k < 16; k++) expQ.push_back(inv[k]);
    expQ.push_back(1'b0);
    waitClk(SYNC + 3);
    checkOutput("first_bit", data_out, expQ.pop_front());
  endtask

  task automatic pulseOnce(input int period, input string tag);
    pulse_in = 1'b1;
    waitClk(period / 2);
    pulse_in = 1'b0;
    waitClk(period / 2);
    if (expQ.size() > 0) checkOutput(tag, data_out, expQ.pop_front());
  endtask

  initial begin
    int fdStart;
    rst = 1'b1; latch_in = 1'b0; pulse_in = 1'b0; buttons = 16'h0000;
    waitClk(3);
    rst = 1'b0;
    waitClk(1);
    checkOutput("rst_data", data_out, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_count", bit_count, 0);
    checkOutput("rst_fdone", frame_done, 0);
    for (int i = 0; i < 5; i++) pulseOnce(20, "unused");
    checkOutput("idle_pulse_data", data_out, 1);
    checkOutput("idle_pulse_busy", busy, 0);
    checkOutput("idle_pulse_count", bit_count, 0);

    // Full frame with exact latch latency check
    fdStart  = fdCount;
    buttons  = 16'h0A05;
    latch_in = 1'b1;
    waitClk(2);
    checkOutput("latency_busy_early", busy, 0);
    waitClk(1);
    checkOutput("latency_busy", busy, 1);
    checkOutput("latency_data", data_out, 0);
    latch_in = 1'b0;
    waitClk(SYNC + 3);
    applyStimulus(16'h0A05, 16'h0A05, 600, 0);
    for (int i = 0; i < 16; i++) pulseOnce(600, "frame_bit");
    checkOutput("frame_count", bit_count, 16);
    checkOutput("frame_busy", busy, 0);
    checkOutput("frame_done_once", fdCount - fdStart, 1);
    buttons = 16'h0000;
    pulseOnce(600, "extra");
    checkOutput("extra_pulse_data", data_out, 0);
    checkOutput("extra_pulse_count", bit_count, 16);

    // Transparent load
    fdStart = fdCount;
    applyStimulus(16'h0000, 16'h0001, 600, 100);
    for (int i = 0; i < 16; i++) pulseOnce(100, "transp_bit");
    checkOutput("transp_done_once", fdCount - fdStart, 1);

    // Restart mid-frame
    fdStart = fdCount;
    applyStimulus(16'h0A05, 16'h0A05, 100, 0);
    for (int i = 0; i < 7; i++) pulseOnce(100, "pre_restart_bit");
    checkOutput("pre_restart_count", bit_count, 7);
    buttons  = 16'h0800;
    latch_in = 1'b1;
    waitClk(SYNC + 4);
    checkOutput("restart_count", bit_count, 0);
    checkOutput("restart_busy", busy, 1);
    latch_in = 1'b0;
    waitClk(SYNC + 3);
    applyStimulus(16'h0800, 16'h0800, 100, 0);
    for (int i = 0; i < 16; i++) pulseOnce(100, "restart_bit");
    checkOutput("restart_done_once", fdCount - fdStart, 1);

    // Timeout after 3 pulses
    fdStart = fdCount;
    applyStimulus(16'h00FF, 16'h00FF, 100, 0);
    for (int i = 0; i < 3; i++) pulseOnce(100, "tmo_bit");
    checkOutput("tmo_busy_before", busy, 1);
    waitClk(TMO + 50);
    checkOutput("tmo_busy", busy, 0);
    checkOutput("tmo_data", data_out, 1);
    checkOutput("tmo_count", bit_count, 3);
    checkOutput("tmo_no_fdone", fdCount - fdStart, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
